// File: rtl/offnariscv_pkg.sv
// Shared core types: default data width, register address type and the packed issue /
// write-back request records used when this block gets a streaming wrapper.
package offnariscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] regaddr_t;

    typedef struct packed {
        regaddr_t [1:0] rs;
        logic [1:0]     rs_used;
        regaddr_t       rd;
        logic           rd_we;
    } iss_req_t;

    typedef struct packed {
        regaddr_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with set-on-issue, clear-on-write-back and flush, plus the
// RAW/WAW hazard decision. Same-cycle resolution of RAW needs REGFILE_SB_WB_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WB   = 2,
    localparam int unsigned AW      = $clog2(RF_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_RD*AW-1:0] iss_rs,
    input  logic [NUM_RD-1:0]    iss_rs_used,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 iss_rd_we,
    input  logic                 set_en,
    input  logic [NUM_WB-1:0]    wb_valid,
    input  logic [NUM_WB*AW-1:0] wb_rd,
    output logic                 hazard,
    output logic [RF_DEPTH-1:0]  busy
);
    import offnariscv_pkg::*;

`ifdef REGFILE_SB_WB_BYPASS_EN
    localparam bit WbBypass = 1'b1;
`else
    localparam bit WbBypass = 1'b0;
`endif

    logic [RF_DEPTH-1:0] busy_q, busy_d;
    logic [RF_DEPTH-1:0] wb_mask;
    logic [AW-1:0]       rs_addr [NUM_RD];

    always_comb begin
        wb_mask = '0;
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && wb_rd[p*AW +: AW] != '0) begin
                wb_mask[wb_rd[p*AW +: AW]] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rs_addr[i] = iss_rs[i*AW +: AW];
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (iss_rs_used[i] && rs_addr[i] != '0 && busy_q[rs_addr[i]] &&
                !(WbBypass && wb_mask[rs_addr[i]])) begin
                hazard = 1'b1;
            end
        end
        // A write-back landing this cycle frees the destination for a new writer.
        if (iss_rd_we && iss_rd != '0 && busy_q[iss_rd] && !wb_mask[iss_rd]) begin
            hazard = 1'b1;
        end
    end

    always_comb begin
        busy_d = busy_q & ~wb_mask;
        if (set_en && iss_rd_we && iss_rd != '0) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with integrated scoreboard and a registered valid/ready operand stage.
// Build option REGFILE_SB_WB_BYPASS_EN forwards write-back data into the operand read.
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WB   = 2,
    localparam int unsigned AW      = $clog2(RF_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_valid,
    output logic                   iss_ready,
    input  logic [NUM_RD*AW-1:0]   iss_rs,
    input  logic [NUM_RD-1:0]      iss_rs_used,
    input  logic [AW-1:0]          iss_rd,
    input  logic                   iss_rd_we,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [NUM_RD*XLEN-1:0] ex_rs_data,
    output logic [AW-1:0]          ex_rd,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*AW-1:0]   wb_rd,
    input  logic [NUM_WB*XLEN-1:0] wb_data,
    input  logic                   flush,
    output logic [RF_DEPTH-1:0]    busy
);
    import offnariscv_pkg::*;

`ifdef REGFILE_SB_WB_BYPASS_EN
    localparam bit WbBypass = 1'b1;
`else
    localparam bit WbBypass = 1'b0;
`endif

    logic [XLEN-1:0]        regs_q [RF_DEPTH];
    logic [XLEN-1:0]        regs_d [RF_DEPTH];
    logic                   ex_valid_q, ex_valid_d;
    logic [NUM_RD*XLEN-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [AW-1:0]          ex_rd_q, ex_rd_d;
    logic [NUM_RD*XLEN-1:0] op_data;
    logic [AW-1:0]          rs_addr [NUM_RD];
    logic [AW-1:0]          wb_addr [NUM_WB];
    logic                   hazard;
    logic                   accept;
    logic                   wb_multi;

    regfile_scoreboard #(
        .RF_DEPTH (RF_DEPTH),
        .NUM_RD   (NUM_RD),
        .NUM_WB   (NUM_WB)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .iss_rs      (iss_rs),
        .iss_rs_used (iss_rs_used),
        .iss_rd      (iss_rd),
        .iss_rd_we   (iss_rd_we),
        .set_en      (accept),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .hazard      (hazard),
        .busy        (busy)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rs_addr[i] = iss_rs[i*AW +: AW];
        end
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            wb_addr[p] = wb_rd[p*AW +: AW];
        end
    end

    assign iss_ready = !rst && !flush && !hazard && (!ex_valid_q || ex_ready);
    assign accept    = iss_valid && iss_ready;

    // Ascending port order makes the highest-indexed colliding port win.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && wb_addr[p] != '0) begin
                regs_d[wb_addr[p]] = wb_data[p*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        op_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (rs_addr[i] != '0) begin
                op_data[i*XLEN +: XLEN] = regs_q[rs_addr[i]];
                for (int unsigned p = 0; p < NUM_WB; p++) begin
                    if (WbBypass && wb_valid[p] && wb_addr[p] == rs_addr[i]) begin
                        op_data[i*XLEN +: XLEN] = wb_data[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rd_d      = ex_rd_q;
        if (accept) begin
            ex_valid_d   = 1'b1;
            ex_rs_data_d = op_data;
            ex_rd_d      = iss_rd;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        if (flush) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= '{default: '0};
            ex_valid_q   <= 1'b0;
            ex_rs_data_q <= '0;
            ex_rd_q      <= '0;
        end else begin
            regs_q       <= regs_d;
            ex_valid_q   <= ex_valid_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rd_q      <= ex_rd_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_rs_data = ex_rs_data_q;
    assign ex_rd      = ex_rd_q;

    always_comb begin
        wb_multi = 1'b0;
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            for (int unsigned q = p + 1; q < NUM_WB; q++) begin
                if (wb_valid[p] && wb_valid[q] && wb_addr[p] == wb_addr[q] &&
                    wb_addr[p] != '0) begin
                    wb_multi = 1'b1;
                end
            end
        end
    end

    // Colliding write-backs are a decoder/pipeline bug; the array still resolves them.
    wb_unique_dest: assert property (@(posedge clk) disable iff (rst) !wb_multi)
        else $warning("regfile_sb: several write-back ports target one register");

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: table of one-cycle vectors plus hand-written stall and
// mid-operation reset sequences. Expected values are hand-computed.
module tb_regfile_sb;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RF_DEPTH = 32;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned NUM_WB = 2;
    localparam int unsigned AW = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   iss_valid;
    logic                   iss_ready;
    logic [NUM_RD*AW-1:0]   iss_rs;
    logic [NUM_RD-1:0]      iss_rs_used;
    logic [AW-1:0]          iss_rd;
    logic                   iss_rd_we;
    logic                   ex_valid;
    logic                   ex_ready;
    logic [NUM_RD*XLEN-1:0] ex_rs_data;
    logic [AW-1:0]          ex_rd;
    logic [NUM_WB-1:0]      wb_valid;
    logic [NUM_WB*AW-1:0]   wb_rd;
    logic [NUM_WB*XLEN-1:0] wb_data;
    logic                   flush;
    logic [RF_DEPTH-1:0]    busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .XLEN     (XLEN),
        .RF_DEPTH (RF_DEPTH),
        .NUM_RD   (NUM_RD),
        .NUM_WB   (NUM_WB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rs      (iss_rs),
        .iss_rs_used (iss_rs_used),
        .iss_rd      (iss_rd),
        .iss_rd_we   (iss_rd_we),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_rs_data  (ex_rs_data),
        .ex_rd       (ex_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .busy        (busy)
    );

    typedef struct {
        string       name;
        logic        iv;
        logic [4:0]  rs1, rs2;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        we, exr, fl;
        logic [1:0]  wbv;
        logic [4:0]  w0r, w1r;
        logic [31:0] w0d, w1d;
        logic        e_rdy, e_exv;
        logic [31:0] e_d1, e_d2;
        logic [4:0]  e_rd;
        logic [31:0] e_busy;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic iv, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [1:0] used,
                                input logic [4:0] rd, input logic we, input logic exr,
                                input logic fl, input logic [1:0] wbv, input logic [4:0] w0r,
                                input logic [31:0] w0d, input logic [4:0] w1r,
                                input logic [31:0] w1d, input logic rdy, input logic exv,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [4:0] erd, input logic [31:0] eb);
        vec_t v;
        v.name = nm; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.used = used; v.rd = rd;
        v.we = we; v.exr = exr; v.fl = fl; v.wbv = wbv; v.w0r = w0r; v.w0d = w0d;
        v.w1r = w1r; v.w1d = w1d; v.e_rdy = rdy; v.e_exv = exv; v.e_d1 = d1; v.e_d2 = d2;
        v.e_rd = erd; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        iss_valid   = v.iv;
        iss_rs      = {v.rs2, v.rs1};
        iss_rs_used = v.used;
        iss_rd      = v.rd;
        iss_rd_we   = v.we;
        ex_ready    = v.exr;
        flush       = v.fl;
        wb_valid    = v.wbv;
        wb_rd       = {v.w1r, v.w0r};
        wb_data     = {v.w1d, v.w0d};
    endtask

    // Called just after a negedge; leaves the bench at the following negedge.
    task automatic apply(input vec_t v);
        drive(v);
        #1;
        chk({v.name, " iss_ready"}, 64'(iss_ready), 64'(v.e_rdy));
        @(posedge clk);
        #1;
        chk({v.name, " ex_valid"}, 64'(ex_valid), 64'(v.e_exv));
        chk({v.name, " ex_rs_data"}, 64'(ex_rs_data), {v.e_d2, v.e_d1});
        chk({v.name, " ex_rd"}, 64'(ex_rd), 64'(v.e_rd));
        chk({v.name, " busy"}, 64'(busy), 64'(v.e_busy));
        @(negedge clk);
    endtask

    vec_t idle;
    vec_t vecs[$];

    initial begin
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //           name            iv rs1 rs2 use rd we exr fl wbv w0r w0d    w1r w1d
        //                           rdy exv d1          d2          erd busy
        vecs.push_back(mk("preload",   0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b11, 5, 32'h1234, 9, 32'h99,
                          1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk("issue_rs5", 1, 5, 0, 2'b11, 3, 1, 0, 0, 2'b00, 0, 0, 0, 0,
                          1, 1, 32'h1234, 0, 3, 32'h8));
        vecs.push_back(mk("hold1",     1, 9, 5, 2'b11, 4, 1, 0, 0, 2'b00, 0, 0, 0, 0,
                          0, 1, 32'h1234, 0, 3, 32'h8));
        vecs.push_back(mk("hold2",     1, 9, 5, 2'b11, 4, 1, 0, 0, 2'b00, 0, 0, 0, 0,
                          0, 1, 32'h1234, 0, 3, 32'h8));
        vecs.push_back(mk("hold3",     1, 9, 5, 2'b11, 4, 1, 0, 0, 2'b00, 0, 0, 0, 0,
                          0, 1, 32'h1234, 0, 3, 32'h8));
        vecs.push_back(mk("release",   1, 9, 5, 2'b11, 4, 1, 1, 0, 2'b00, 0, 0, 0, 0,
                          1, 1, 32'h99, 32'h1234, 4, 32'h18));
        vecs.push_back(mk("drain",     0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0,
                          1, 0, 32'h99, 32'h1234, 4, 32'h18));
        vecs.push_back(mk("waw_wb",    1, 0, 0, 2'b00, 4, 1, 1, 0, 2'b01, 4, 32'h44, 0, 0,
                          1, 1, 0, 0, 4, 32'h18));
        vecs.push_back(mk("waw_stall", 1, 0, 0, 2'b00, 3, 1, 1, 0, 2'b00, 0, 0, 0, 0,
                          0, 0, 0, 0, 4, 32'h18));
        vecs.push_back(mk("unused_src",1, 3, 4, 2'b00, 10, 0, 1, 0, 2'b00, 0, 0, 0, 0,
                          1, 1, 0, 32'h44, 10, 32'h18));
        vecs.push_back(mk("rd_x0",     1, 0, 0, 2'b01, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0,
                          1, 1, 0, 0, 0, 32'h18));
        vecs.push_back(mk("wb_x0",     1, 0, 9, 2'b11, 0, 0, 1, 0, 2'b01, 0, 32'hFFFF, 0, 0,
                          1, 1, 0, 32'h99, 0, 32'h18));
        vecs.push_back(mk("dual_wb7",  0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b11, 7, 32'h11, 7, 32'h22,
                          1, 0, 0, 32'h99, 0, 32'h18));
        vecs.push_back(mk("read_x7",   1, 7, 5, 2'b11, 9, 1, 1, 0, 2'b00, 0, 0, 0, 0,
                          1, 1, 32'h22, 32'h1234, 9, 32'h218));
        vecs.push_back(mk("wb_x4",     0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 4, 32'h4444,
                          0, 1, 32'h22, 32'h1234, 9, 32'h208));
        vecs.push_back(mk("flush",     1, 3, 0, 2'b01, 5, 1, 0, 1, 2'b01, 6, 32'h66, 0, 0,
                          0, 0, 32'h22, 32'h1234, 9, 32'h0));
        vecs.push_back(mk("post_flush",1, 3, 6, 2'b11, 2, 1, 0, 0, 2'b00, 0, 0, 0, 0,
                          1, 1, 0, 32'h66, 2, 32'h4));

        rst = 1'b1;
        drive(idle);
        @(posedge clk);
        #1;
        chk("reset iss_ready", 64'(iss_ready), 64'd0);
        chk("reset ex_valid", 64'(ex_valid), 64'd0);
        chk("reset ex_rs_data", 64'(ex_rs_data), 64'd0);
        chk("reset ex_rd", 64'(ex_rd), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // RAW dependency on x2 (busy from post_flush), resolved by write-back of 0xCAFE.
        apply(mk("raw_stall", 1, 2, 0, 2'b01, 8, 0, 1, 0, 2'b00, 0, 0, 0, 0,
                 0, 0, 0, 32'h66, 2, 32'h4));
`ifdef REGFILE_SB_WB_BYPASS_EN
        apply(mk("raw_wb", 1, 2, 0, 2'b01, 8, 0, 1, 0, 2'b01, 2, 32'hCAFE, 0, 0,
                 1, 1, 32'hCAFE, 0, 8, 32'h0));
`else
        apply(mk("raw_wb", 1, 2, 0, 2'b01, 8, 0, 1, 0, 2'b01, 2, 32'hCAFE, 0, 0,
                 0, 0, 0, 32'h66, 2, 32'h0));
        apply(mk("raw_accept", 1, 2, 0, 2'b01, 8, 0, 1, 0, 2'b00, 0, 0, 0, 0,
                 1, 1, 32'hCAFE, 0, 8, 32'h0));
`endif

        // Reset with a pending output, a busy register and a concurrent write-back.
        apply(mk("pre_reset", 1, 0, 0, 2'b00, 12, 1, 1, 0, 2'b00, 0, 0, 0, 0,
                 1, 1, 0, 0, 12, 32'h1000));
        drive(mk("mid_reset", 1, 5, 0, 2'b01, 14, 1, 0, 0, 2'b01, 13, 32'hDEAD, 0, 0,
                 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        chk("mid_reset iss_ready", 64'(iss_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("mid_reset ex_valid", 64'(ex_valid), 64'd0);
        chk("mid_reset ex_rs_data", 64'(ex_rs_data), 64'd0);
        chk("mid_reset ex_rd", 64'(ex_rd), 64'd0);
        chk("mid_reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk("after_reset", 1, 13, 5, 2'b11, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0,
                 1, 1, 0, 0, 1, 32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor register file with an integrated scoreboard.
- Accepts issue requests from the decoder and reads up to NUM_RD source registers.
- Stalls on read-after-write and write-after-write hazards using per-register busy bits.
- Absorbs NUM_WB independent write-back ports per cycle.
- Presents operands to execution units through a registered valid/ready output stage.

Parameters:
XLEN, 32, data width of each register
RF_DEPTH, 32, number of architectural registers (power of two, >=2)
NUM_RD, 2, source read ports per issue
NUM_WB, 2, write-back ports per cycle
AW, $clog2(RF_DEPTH), register address width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iss_valid  in  1  issue request valid
iss_ready  out  1  issue accepted this cycle when high with iss_valid
iss_rs  in  NUM_RD*AW  source register addresses
iss_rs_used  in  NUM_RD  per-source use flag; unused sources never cause hazards
iss_rd  in  AW  destination register
iss_rd_we  in  1  instruction writes iss_rd
ex_valid  out  1  operand stage valid
ex_ready  in  1  execution units accept
ex_rs_data  out  NUM_RD*XLEN  source operand data
ex_rd  out  AW  registered destination
wb_valid  in  NUM_WB  write-back valid per port
wb_rd  in  NUM_WB*AW  write-back destination per port
wb_data  in  NUM_WB*XLEN  write-back data per port
flush  in  1  pipeline invalidate
busy  out  RF_DEPTH  scoreboard state, observability only

Behaviour:
- Reset, synchronous on rst=1 at posedge clk:
  - all registers cleared to 0
  - busy cleared to 0
  - ex_valid=0; ex_rs_data and ex_rd cleared to 0
  - iss_ready is 0 while rst=1
- Hazard, per source i: iss_rs_used[i] && iss_rs[i]!=0 && busy[iss_rs[i]] && not resolved this cycle.
  - With bypass compiled in, a source is resolved when a valid wb port writes iss_rs[i] in the same cycle.
- WAW hazard: iss_rd_we && iss_rd!=0 && busy[iss_rd] && no wb to iss_rd this cycle.
- Readiness: iss_ready = !rst && !flush && no hazard && (!ex_valid || ex_ready). Acceptance is independent of iss_valid (no combinational path from iss_valid to iss_ready).
- On accept, at the next edge:
  - ex_valid=1
  - ex_rs_data captures operands; register x0 always reads 0
  - ex_rd captures iss_rd
  - busy[iss_rd] is set if iss_rd_we && iss_rd!=0
- Latency: one cycle from accept to ex_valid.
- Output stage: ex_valid holds with stable data until ex_ready; it drops when ex_ready=1 and no new accept occurs.
- Write-back:
  - Each valid port with wb_rd!=0 writes its register and clears its busy bit.
  - Multiple ports to the same rd in one cycle: highest port index wins. This is illegal use and must be covered by an assertion.
  - Writes to x0 are ignored.
- Same-cycle set and clear on one register: the set from a new issue wins; the register ends busy.
- flush:
  - forces ex_valid=0 at the next edge
  - clears all busy bits
  - blocks issue that cycle
  - write-backs in the flush cycle still update the array
- Reset mid-operation discards the pending output and the scoreboard; no write-back is performed in the reset cycle.

Optional Feature:
- Macro: REGFILE_SB_WB_BYPASS_EN.
- Defined: write-back data forwards combinationally into the operand read (highest matching port wins) and resolves hazards in the same cycle.
- Undefined: operands come from the array only; a busy source stalls until the cycle after its write-back, adding one bubble per dependency.

Decomposition:
- Package offnariscv_pkg: XLEN, regaddr_t, and packed issue/write-back request structs for future axis_if wrapping.
- Sub-module regfile_scoreboard: holds the busy vector, set/clear/flush logic and hazard outputs.
- The array and operand stage stay in regfile_sb.

Test Plan:
- Reset, then issue rs1=5, rs2=0, rd=3 with x5=0x1234 preloaded via wb -> ex_rs_data={0,0x1234} after 1 cycle; busy[3]=1.
- Issue rd=3; next issue reads rs1=3 with no wb -> iss_ready=0 until wb_rd=3, data 0xCAFE.
  - With bypass: accepted in the wb cycle with 0xCAFE.
  - Without bypass: accepted one cycle later with 0xCAFE.
- Two wb ports both valid to rd=7 with 0x11 (port 0) and 0x22 (port 1) -> x7=0x22; assertion fires.
- ex_ready=0 for 3 cycles with ex_valid=1 -> iss_ready=0, ex_rs_data stable; ex_ready=1 -> next issue accepted the same cycle.
- Issue rd=0 with iss_rd_we=1, then wb to x0 with 0xFFFF -> busy[0] stays 0; reading x0 returns 0.
- flush with busy={3,9}, ex_valid=1 -> next cycle busy=0, ex_valid=0; an issue reading x3 is accepted immediately.
